// File: rtl/exec_stage.sv
// Execute stage: ID/EX register, forwarding, ARM condition check, ALU and NZCV.
// Define EXEC_MUL_EN to include the iterative shift-add multiplier (op 110).
module exec_stage #(
    parameter int WIDTH   = 32,
    parameter int REGBITS = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stallE,
    input  logic               flushE,
    input  logic               PCSrcD,
    input  logic               RegWriteD,
    input  logic               MemtoRegD,
    input  logic               MemWriteD,
    input  logic               BranchD,
    input  logic               ALUSrcD,
    input  logic [1:0]         FlagWriteD,
    input  logic [2:0]         ALUControlD,
    input  logic [3:0]         CondD,
    input  logic [REGBITS-1:0] RdD,
    input  logic [REGBITS-1:0] RA1D,
    input  logic [REGBITS-1:0] RA2D,
    input  logic [WIDTH-1:0]   Rd1D,
    input  logic [WIDTH-1:0]   Rd2D,
    input  logic [WIDTH-1:0]   ExtD,
    input  logic [1:0]         forwardAE,
    input  logic [1:0]         forwardBE,
    input  logic [WIDTH-1:0]   ResultW,
    input  logic [WIDTH-1:0]   ALUResultM,
    output logic               RegWriteE,
    output logic               MemWriteE,
    output logic               MemtoRegE,
    output logic               PCSrcE,
    output logic               BranchTakenE,
    output logic               BusyE,
    output logic [REGBITS-1:0] RdE,
    output logic [REGBITS-1:0] RA1E,
    output logic [REGBITS-1:0] RA2E,
    output logic [WIDTH-1:0]   ALUResultE,
    output logic [WIDTH-1:0]   WriteDataE,
    output logic [3:0]         FlagsE
);
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_ORR = 3'b011;
    localparam logic [2:0] OP_EOR = 3'b100;
    localparam logic [2:0] OP_MOV = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;
    localparam logic [2:0] OP_BIC = 3'b111;

    typedef struct packed {
        logic               pcsrc;
        logic               regwrite;
        logic               memtoreg;
        logic               memwrite;
        logic               branch;
        logic               alusrc;
        logic [1:0]         flagwrite;
        logic [2:0]         aluctl;
        logic [3:0]         cond;
        logic [REGBITS-1:0] rd;
        logic [REGBITS-1:0] ra1;
        logic [REGBITS-1:0] ra2;
        logic [WIDTH-1:0]   rd1;
        logic [WIDTH-1:0]   rd2;
        logic [WIDTH-1:0]   ext;
    } e_fields_t;

    e_fields_t        e_r;
    logic [3:0]       flags_r;
    logic             busy_s;
    logic             condex_s;
    logic             flag_we_s;
    logic             carry_s;
    logic             ovf_s;
    logic [WIDTH-1:0] opa_s;
    logic [WIDTH-1:0] opb_s;
    logic [WIDTH-1:0] wd_s;
    logic [WIDTH-1:0] alu_s;
    logic [WIDTH-1:0] mul_result_s;

    function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        case (cond)
            4'b0000: cond_eval = z;
            4'b0001: cond_eval = ~z;
            4'b0010: cond_eval = c;
            4'b0011: cond_eval = ~c;
            4'b0100: cond_eval = n;
            4'b0101: cond_eval = ~n;
            4'b0110: cond_eval = v;
            4'b0111: cond_eval = ~v;
            4'b1000: cond_eval = c & ~z;
            4'b1001: cond_eval = ~c | z;
            4'b1010: cond_eval = (n == v);
            4'b1011: cond_eval = (n != v);
            4'b1100: cond_eval = ~z & (n == v);
            4'b1101: cond_eval = z | (n != v);
            default: cond_eval = 1'b1;
        endcase
    endfunction

    // ID/EX register: flush beats stall, and a running multiply also holds it
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            e_r <= '0;
        end else if (flushE) begin
            e_r <= '0;
        end else if (!(stallE || busy_s)) begin
            e_r <= {PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD, FlagWriteD,
                    ALUControlD, CondD, RdD, RA1D, RA2D, Rd1D, Rd2D, ExtD};
        end
    end

    // Operand forwarding muxes
    always_comb begin
        case (forwardAE)
            2'b01:   opa_s = ResultW;
            2'b10:   opa_s = ALUResultM;
            default: opa_s = e_r.rd1;
        endcase
        case (forwardBE)
            2'b01:   wd_s = ResultW;
            2'b10:   wd_s = ALUResultM;
            default: wd_s = e_r.rd2;
        endcase
        if (e_r.alusrc) begin
            opb_s = e_r.ext;
        end else begin
            opb_s = wd_s;
        end
    end

    // ALU; carry and overflow are only meaningful for ADD and SUB
    always_comb begin
        alu_s   = {WIDTH{1'b0}};
        carry_s = 1'b0;
        ovf_s   = 1'b0;
        case (e_r.aluctl)
            OP_ADD: begin
                {carry_s, alu_s} = {1'b0, opa_s} + {1'b0, opb_s};
                ovf_s = (opa_s[WIDTH-1] == opb_s[WIDTH-1]) && (alu_s[WIDTH-1] != opa_s[WIDTH-1]);
            end
            OP_SUB: begin
                {carry_s, alu_s} = {1'b0, opa_s} + {1'b0, ~opb_s} + {{WIDTH{1'b0}}, 1'b1};
                ovf_s = (opa_s[WIDTH-1] != opb_s[WIDTH-1]) && (alu_s[WIDTH-1] != opa_s[WIDTH-1]);
            end
            OP_AND:  alu_s = opa_s & opb_s;
            OP_ORR:  alu_s = opa_s | opb_s;
            OP_EOR:  alu_s = opa_s ^ opb_s;
            OP_MOV:  alu_s = opb_s;
            OP_MUL:  alu_s = mul_result_s;
            OP_BIC:  alu_s = opa_s & ~opb_s;
            default: alu_s = {WIDTH{1'b0}};
        endcase
    end

`ifdef EXEC_MUL_EN
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE = 2'b00, RUN = 2'b01, DONE = 2'b10} mul_state_t;

    mul_state_t       state_r;
    logic [WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0] mplier_r;
    logic [WIDTH-1:0] prod_r;
    logic [CW-1:0]    count_r;
    logic             mul_start_s;

    // The entry cycle already performs step 0, so busy spans exactly WIDTH cycles
    assign mul_start_s  = (state_r == IDLE) && (e_r.aluctl == OP_MUL) && condex_s && !flushE;
    assign busy_s       = mul_start_s || (state_r == RUN);
    assign mul_result_s = (state_r == DONE) ? prod_r : {WIDTH{1'b0}};

    // Shift-add multiplier sequencer with latched operands
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r  <= IDLE;
            mcand_r  <= {WIDTH{1'b0}};
            mplier_r <= {WIDTH{1'b0}};
            prod_r   <= {WIDTH{1'b0}};
            count_r  <= CW'(0);
        end else begin
            case (state_r)
                IDLE: begin
                    if (mul_start_s) begin
                        state_r  <= RUN;
                        prod_r   <= opb_s[0] ? opa_s : {WIDTH{1'b0}};
                        mcand_r  <= opa_s << 1;
                        mplier_r <= opb_s >> 1;
                        count_r  <= CW'(WIDTH - 1);
                    end
                end
                RUN: begin
                    if (flushE) begin
                        state_r <= IDLE;
                    end else begin
                        if (mplier_r[0]) begin
                            prod_r <= prod_r + mcand_r;
                        end
                        mcand_r  <= mcand_r << 1;
                        mplier_r <= mplier_r >> 1;
                        count_r  <= count_r - CW'(1);
                        if (count_r == CW'(1)) begin
                            state_r <= DONE;
                        end
                    end
                end
                DONE: begin
                    if (flushE || !stallE) begin
                        state_r <= IDLE;
                    end
                end
                default: state_r <= IDLE;
            endcase
        end
    end
`else
    assign busy_s       = 1'b0;
    assign mul_result_s = {WIDTH{1'b0}};
`endif

    assign condex_s  = cond_eval(e_r.cond, flags_r);
    assign flag_we_s = condex_s && !stallE && !busy_s;

    // NZCV register; C/V only move on ADD/SUB
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flags_r <= 4'b0000;
        end else begin
            if (flag_we_s && e_r.flagwrite[1]) begin
                flags_r[3:2] <= {alu_s[WIDTH-1], (alu_s == {WIDTH{1'b0}})};
            end
            if (flag_we_s && e_r.flagwrite[0] && ((e_r.aluctl == OP_ADD) || (e_r.aluctl == OP_SUB))) begin
                flags_r[1:0] <= {carry_s, ovf_s};
            end
        end
    end

    assign RegWriteE    = e_r.regwrite & condex_s & ~busy_s;
    assign MemWriteE    = e_r.memwrite & condex_s & ~busy_s;
    assign MemtoRegE    = e_r.memtoreg;
    assign PCSrcE       = e_r.pcsrc & condex_s;
    assign BranchTakenE = e_r.branch & condex_s;
    assign BusyE        = busy_s;
    assign RdE          = e_r.rd;
    assign RA1E         = e_r.ra1;
    assign RA2E         = e_r.ra2;
    assign ALUResultE   = alu_s;
    assign WriteDataE   = wd_s;
    assign FlagsE       = flags_r;
endmodule

// File: doc/exec_stage.md
# exec_stage

Parametrised execute stage for the pipelined ARM core, the successor to the fixed 32-bit execute block. It contains:
- the ID/EX pipeline register, with stall and flush;
- three-way operand forwarding;
- condition evaluation against an internal NZCV status register;
- a single-cycle ALU;
- an iterative shift-add multiplier that stalls the pipeline while it runs.

It sits between decode and memory. Its gated control outputs feed the EX/MEM register and the hazard unit.

## Interface
Parameters:
- WIDTH, 32: datapath width; must be ≥ 8.
- REGBITS, 4: register-address width.

Ports:
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  asynchronous, active-high.
- stallE  in  1  hold the E register (from hazard unit).
- flushE  in  1  load a bubble into the E register.
- PCSrcD, RegWriteD, MemtoRegD, MemWriteD, BranchD, ALUSrcD  in  1 each  decoded controls.
- FlagWriteD  in  2  [1]=NZ enable, [0]=CV enable.
- ALUControlD  in  3  operation code.
- CondD  in  4  ARM condition field.
- RdD, RA1D, RA2D  in  REGBITS  destination and source addresses.
- Rd1D, Rd2D, ExtD  in  WIDTH  register operands and immediate.
- forwardAE, forwardBE  in  2  00=register, 01=ResultW, 10=ALUResultM, 11=register.
- ResultW, ALUResultM  in  WIDTH  forwarding sources.
- RegWriteE, MemWriteE, MemtoRegE, PCSrcE, BranchTakenE  out  1  condition-gated controls.
- BusyE  out  1  multiplier running; hazard unit must stall F/D.
- RdE, RA1E, RA2E  out  REGBITS  registered addresses.
- ALUResultE, WriteDataE  out  WIDTH  result and forwarded operand B.
- FlagsE  out  4  current NZCV.

## Operation
**E register**
- On each edge: if flushE, all control fields load 0 (address and data fields load 0). Else if stallE or BusyE, hold. Else load all D inputs.
- Flush has priority over stall.

**Forwarding**
- OpA = mux(forwardAE). WriteDataE = mux(forwardBE).
- OpB = ExtE when ALUSrcE=1, else WriteDataE.

**Condition evaluation**
- CondExE is evaluated from CondE and FlagsE using the standard ARM EQ..AL decoding.
- Code 1111 is treated as AL.

**Control gating**
- RegWriteE = RegWriteRegE & CondExE & ~BusyE.
- MemWriteE = MemWriteRegE & CondExE & ~BusyE.
- PCSrcE = PCSrcRegE & CondExE.
- BranchTakenE = BranchRegE & CondExE.
- MemtoRegE is not gated.

**ALU operations** (modulo 2^WIDTH):
- 000 ADD, 001 SUB (A−B), 010 AND, 011 ORR, 100 EOR, 101 MOV (B), 110 MUL, 111 BIC (A&~B).
- N = result MSB; Z = result==0.
- C and V are produced only by ADD/SUB, as ARM defines them (C = carry-out, or NOT borrow for SUB).

**Flag write**
- FlagsE[3:2] update when FlagWriteE[1] & CondExE & ~stallE & ~BusyE.
- FlagsE[1:0] update under the same gating with FlagWriteE[0], but only for ADD and SUB. They are unchanged for all other operations.

**Multiplier FSM**, states IDLE, RUN, DONE:
- IDLE→RUN when the E register holds MUL, CondExE=1 and ~flushE. On this transition the block latches OpA and OpB and loads count=WIDTH−1.
- RUN: one shift-add step per cycle, count decrements. RUN→DONE when count==0.
- DONE: ALUResultE = product[WIDTH−1:0]. Gated controls and flags are released. DONE→IDLE on the next edge, or holds in DONE while stallE=1.
- BusyE=1 in the IDLE→RUN entry cycle and in RUN, for exactly WIDTH cycles. BusyE=0 in DONE.
- A MUL whose condition fails takes one cycle and does no write.
- flushE in RUN or DONE aborts the multiply: the FSM returns to IDLE and BusyE drops on the next edge.
- Latched operands are immune to later forwarding-source changes.

## Timing
- Reset values:
  - E register all zero; FlagsE=0000; FSM=IDLE.
  - BusyE, RegWriteE, MemWriteE, MemtoRegE, PCSrcE and BranchTakenE are 0.
  - ALUResultE and WriteDataE are 0 (with forward selects 00).
- Latency:
  - Non-MUL operations: result is combinational in the cycle after the D inputs are captured.
  - MUL: result appears WIDTH cycles after capture and is valid for one cycle (longer if stallE is held).
- Flags written by the instruction in E are visible to the next instruction's condition one cycle later.
- Asserting reset mid-multiply returns to IDLE immediately (asynchronously).

## Configuration
EXEC_MUL_EN:
- Defined: the multiplier FSM is present as specified above.
- Undefined: the FSM and its operand latches are omitted and BusyE is tied to 0. Op 110 produces ALUResultE=0 in one cycle, with normal gating; N/Z are written if enabled, so Z=1.

## Test plan
- Reset: assert reset mid-cycle → all outputs 0 and FlagsE=0000 without waiting for a clock edge.
- SUBS 5−5, FlagWriteD=11 → ALUResultE=0; FlagsE=0110 on the next edge. A following ADDEQ writes and a following ADDNE is squashed (RegWriteE=0).
- Forwarding:
  - forwardAE=10 with ALUResultM=7 and Rd1D=1, ADD with ExtD=3 and ALUSrcD=1 → ALUResultE=10.
  - forwardBE=01 with ResultW=0xAA → WriteDataE=0xAA.
- MUL 6×7 at WIDTH=32 → BusyE high exactly 32 cycles; then ALUResultE=42 with RegWriteE=1 for one cycle. Changing ResultW during RUN does not affect the result.
- flushE asserted 5 cycles into a MUL → BusyE=0 after the edge and no register write. A stallE pulse on a flag-setting ADDS does not double-apply its flags or change its own CondExE.
- With EXEC_MUL_EN undefined, MUL → BusyE never rises; ALUResultE=0 in one cycle.
